// File: rtl/dmem_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_if
// Description : Request/response bundle between the memory-stage initiator
//               and the data-memory responder. Two valid/ready channels:
//                 request  : req_valid, req_ready, req_write, req_addr,
//                            req_wdata
//                 response : resp_valid, resp_ready, resp_rdata, resp_err
//               Modports:
//                 master - initiator side (drives req_*, resp_ready)
//                 slave  - responder side (drives req_ready, resp_*)
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Data-memory responder for the sequential Y86-64 core.
//               Serves one 8-byte little-endian read or write per request
//               from a byte array, one byte per cycle after WAIT_CYCLES
//               idle cycles. Out-of-range addresses return resp_err.
// Ports       : clk     - clock, rising edge
//               rst     - synchronous active-high reset
//               bus     - dmem_if.slave request/response channels
//               busy    - high whenever the FSM is not idle
//               ld_en   - preload strobe (honoured only while idle)
//               ld_addr - preload byte address
//               ld_data - preload byte
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int MEM_BYTES   = 4096,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  dmem_if.slave                        bus,
  output logic                         busy,
  input  logic                         ld_en,
  input  logic [$clog2(MEM_BYTES)-1:0] ld_addr,
  input  logic [7:0]                   ld_data
);

  localparam int AW = $clog2(MEM_BYTES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_XFER = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nx;

  logic [15:0]   wait_cnt;
  logic [2:0]    byte_idx;
  logic          op_write;
  logic [AW-1:0] op_addr;
  logic [63:0]   op_wdata;
  logic [63:0]   rdata_acc;
  logic          err_flag;

  logic [7:0]    mem [MEM_BYTES];

  logic          addr_err;
  logic [AW-1:0] byte_addr;
  logic [5:0]    lane;

  // Full 64-bit compare: any address whose 8-byte window leaves the array.
  assign addr_err  = bus.req_addr > 64'(MEM_BYTES - 8);
  // In-range requests never wrap, so the low address bits suffice here.
  assign byte_addr = op_addr + AW'(byte_idx);
  assign lane      = {byte_idx, 3'b000};

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (bus.req_valid) begin
          // Error responses take one cycle in WAIT so resp_valid rises
          // after the edge following acceptance, independent of WAIT_CYCLES.
          if (addr_err || (WAIT_CYCLES != 0)) begin
            state_nx = S_WAIT;
          end else begin
            state_nx = S_XFER;
          end
        end
      end
      S_WAIT: begin
        if (err_flag) begin
          state_nx = S_RESP;
        end else if (wait_cnt == 16'(WAIT_CYCLES - 1)) begin
          state_nx = S_XFER;
        end
      end
      S_XFER: begin
        if (byte_idx == 3'd7) begin
          state_nx = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Request latch, counters and read accumulator
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt  <= '0;
      byte_idx  <= '0;
      op_write  <= 1'b0;
      op_addr   <= '0;
      op_wdata  <= '0;
      rdata_acc <= '0;
      err_flag  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            op_write  <= bus.req_write;
            op_addr   <= bus.req_addr[AW-1:0];
            op_wdata  <= bus.req_wdata;
            rdata_acc <= '0;
            err_flag  <= addr_err;
            wait_cnt  <= '0;
            byte_idx  <= '0;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + 16'd1;
          byte_idx <= '0;
        end
        S_XFER: begin
          byte_idx <= byte_idx + 3'd1;
          if (!op_write) begin
            rdata_acc[lane +: 8] <= mem[byte_addr];
          end
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Byte array: preload only while idle, serial write only during XFER.
  // Contents survive reset.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      if ((state == S_IDLE) && ld_en) begin
        mem[ld_addr] <= ld_data;
      end else if ((state == S_XFER) && op_write) begin
        mem[byte_addr] <= op_wdata[lane +: 8];
      end
    end
  end

  assign bus.req_ready  = (state == S_IDLE);
  assign bus.resp_valid = (state == S_RESP);
  assign bus.resp_rdata = rdata_acc;
  assign bus.resp_err   = err_flag;
  assign busy           = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed self-checking bench for dmem_responder. Drives a
//               WAIT_CYCLES=2 instance (a) and a WAIT_CYCLES=0 instance (b);
//               sel chooses which one receives req_valid / ld_en.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sel;
  logic        req_valid;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_ready;
  logic        ld_en;
  logic [11:0] ld_addr;
  logic [7:0]  ld_data;
  logic        busy_a;
  logic        busy_b;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_if bus_a ();
  dmem_if bus_b ();

  assign bus_a.req_valid  = req_valid & ~sel;
  assign bus_a.req_write  = req_write;
  assign bus_a.req_addr   = req_addr;
  assign bus_a.req_wdata  = req_wdata;
  assign bus_a.resp_ready = resp_ready;
  assign bus_b.req_valid  = req_valid & sel;
  assign bus_b.req_write  = req_write;
  assign bus_b.req_addr   = req_addr;
  assign bus_b.req_wdata  = req_wdata;
  assign bus_b.resp_ready = resp_ready;

  wire        req_ready_m  = sel ? bus_b.req_ready  : bus_a.req_ready;
  wire        resp_valid_m = sel ? bus_b.resp_valid : bus_a.resp_valid;
  wire [63:0] resp_rdata_m = sel ? bus_b.resp_rdata : bus_a.resp_rdata;
  wire        resp_err_m   = sel ? bus_b.resp_err   : bus_a.resp_err;
  wire        busy_m       = sel ? busy_b           : busy_a;

  dmem_responder #(.MEM_BYTES(4096), .WAIT_CYCLES(2)) u_dut_a (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus_a),
    .busy    (busy_a),
    .ld_en   (ld_en & ~sel),
    .ld_addr (ld_addr),
    .ld_data (ld_data)
  );

  dmem_responder #(.MEM_BYTES(4096), .WAIT_CYCLES(0)) u_dut_b (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus_b),
    .busy    (busy_b),
    .ld_en   (ld_en & sel),
    .ld_addr (ld_addr),
    .ld_data (ld_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [7:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    tick();
    ld_en   = 1'b0;
  endtask

  // Issue one request with resp_ready held high; check latency (edges after
  // the accepting edge until resp_valid), payload, and the return to idle.
  task automatic request(input string tag, input logic w, input logic [63:0] a,
                         input logic [63:0] wd, input int exp_lat,
                         input logic [63:0] exp_rd, input logic exp_err);
    int n;
    req_valid  = 1'b1;
    req_write  = w;
    req_addr   = a;
    req_wdata  = wd;
    resp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid_m && n < 60) begin
      tick();
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(exp_lat));
    check({tag, " resp_valid"}, {63'd0, resp_valid_m}, 64'd1);
    check({tag, " rdata"}, resp_rdata_m, exp_rd);
    check({tag, " err"}, {63'd0, resp_err_m}, {63'd0, exp_err});
    tick();
    check({tag, " req_ready after hs"}, {63'd0, req_ready_m}, 64'd1);
    check({tag, " resp_valid after hs"}, {63'd0, resp_valid_m}, 64'd0);
  endtask

  initial begin
    int n;
    sel        = 1'b0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b1;
    ld_en      = 1'b0;
    ld_addr    = '0;
    ld_data    = '0;

    // Reset state
    repeat (3) tick();
    check("reset req_ready", {63'd0, req_ready_m}, 64'd1);
    check("reset resp_valid", {63'd0, resp_valid_m}, 64'd0);
    check("reset rdata", resp_rdata_m, 64'd0);
    check("reset err", {63'd0, resp_err_m}, 64'd0);
    check("reset busy", {63'd0, busy_m}, 64'd0);
    rst = 1'b0;
    tick();

    // Preloaded aligned read
    for (int i = 0; i < 8; i++) preload(12'(12'h100 + i), 8'(i + 1));
    request("rd 100", 1'b0, 64'h100, 64'd0, 10, 64'h0807060504030201, 1'b0);

    // Unaligned write/read across 0x7F9..0x800
    preload(12'h7F8, 8'h5A);
    request("wr 7F9", 1'b1, 64'h7F9, 64'h1122334455667788, 10, 64'd0, 1'b0);
    request("rd 7F9", 1'b0, 64'h7F9, 64'd0, 10, 64'h1122334455667788, 1'b0);
    request("rd 7F8", 1'b0, 64'h7F8, 64'd0, 10, 64'h223344556677885A, 1'b0);

    // Range boundaries
    request("rd FF9 err", 1'b0, 64'hFF9, 64'd0, 1, 64'd0, 1'b1);
    for (int i = 0; i < 8; i++) preload(12'(12'hFF8 + i), 8'(8'hC0 + i));
    request("rd FF8", 1'b0, 64'hFF8, 64'd0, 10, 64'hC7C6C5C4C3C2C1C0, 1'b0);
    for (int i = 0; i < 8; i++) preload(12'(i), 8'(8'hA0 + i));
    request("wr 2^63 err", 1'b1, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF,
            1, 64'd0, 1'b1);
    request("rd 000 after err", 1'b0, 64'h0, 64'd0, 10, 64'hA7A6A5A4A3A2A1A0, 1'b0);

    // Back-pressure: hold resp_ready low for 5 cycles in RESP
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_addr   = 64'h100;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid_m && n < 60) begin
      tick();
      n++;
    end
    check("hold latency", 64'(n), 64'd10);
    for (int k = 0; k < 5; k++) begin
      check("hold resp_valid", {63'd0, resp_valid_m}, 64'd1);
      check("hold rdata", resp_rdata_m, 64'h0807060504030201);
      check("hold err", {63'd0, resp_err_m}, 64'd0);
      check("hold req_ready", {63'd0, req_ready_m}, 64'd0);
      check("hold busy", {63'd0, busy_m}, 64'd1);
      if (k == 2) begin
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 64'h100;
        req_wdata = 64'hFFFFFFFFFFFFFFFF;
      end
      tick();
      req_valid = 1'b0;
    end
    resp_ready = 1'b1;
    tick();
    check("hold release req_ready", {63'd0, req_ready_m}, 64'd1);
    request("rd 100 after hold", 1'b0, 64'h100, 64'd0, 10,
            64'h0807060504030201, 1'b0);

    // Reset after three XFER edges of a write
    for (int i = 0; i < 8; i++) preload(12'(12'h200 + i), 8'h00);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 64'h200;
    req_wdata = 64'hAABBCCDDEEFF0011;
    tick();                 // edge 0: accept
    req_valid = 1'b0;
    repeat (5) tick();      // edges 1-2 wait, 3-5 write bytes 0..2
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst req_ready", {63'd0, req_ready_m}, 64'd1);
    check("midrst resp_valid", {63'd0, resp_valid_m}, 64'd0);
    check("midrst busy", {63'd0, busy_m}, 64'd0);
    request("rd 200 after rst", 1'b0, 64'h200, 64'd0, 10,
            64'h0000000000FF0011, 1'b0);

    // Zero-wait instance
    sel = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) preload(12'(12'h300 + i), 8'(8'h10 + i));
    request("b rd 300", 1'b0, 64'h300, 64'd0, 8, 64'h1716151413121110, 1'b0);

    // Preload attempts while busy are ignored
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_addr   = 64'h300;
    tick();
    req_valid = 1'b0;
    ld_en     = 1'b1;
    ld_addr   = 12'h300;
    ld_data   = 8'hEE;
    check("b busy during ld", {63'd0, busy_m}, 64'd1);
    n = 0;
    while (!resp_valid_m && n < 60) begin
      tick();
      n++;
    end
    ld_en = 1'b0;
    check("b ld-busy latency", 64'(n), 64'd8);
    check("b ld-busy rdata", resp_rdata_m, 64'h1716151413121110);
    resp_ready = 1'b1;
    tick();
    request("b rd 300 again", 1'b0, 64'h300, 64'd0, 8, 64'h1716151413121110, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
